// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_tx_arbiter and the uart_rx / uart_tx blocks.
// Contents:
//   word_width_default - default bits per UART word
//   state_e            - arbiter FSM state encoding
//   idx_width()        - index width for n items, never less than one bit
package uart_pkg;

  localparam int unsigned word_width_default = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT
  } state_e;

  // Bits needed to hold an index in 0..n-1, with a floor of one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundles the requester handshake and the transmitter load interface of uart_tx_arbiter.
//   req_valid   per-requester byte available
//   req_data    flattened bytes, requester i at [i*word_width +: word_width]
//   req_ready   one-hot acceptance pulse
//   tx_byte     byte presented to the transmitter
//   tx_start    one-cycle load pulse to the transmitter
//   tx_done     one-cycle completion pulse from the transmitter
//   busy        arbiter is not idle
//   grant_idx   index of the last granted requester
//   timeout_err watchdog expiry pulse
// Modports: master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned num_req    = 3,
  parameter int unsigned word_width = uart_pkg::word_width_default,
  localparam int unsigned idx_w     = uart_pkg::idx_width(num_req)
);

  logic [num_req-1:0]            req_valid;
  logic [num_req*word_width-1:0] req_data;
  logic [num_req-1:0]            req_ready;
  logic [word_width-1:0]         tx_byte;
  logic                          tx_start;
  logic                          tx_done;
  logic                          busy;
  logic [idx_w-1:0]              grant_idx;
  logic                          timeout_err;

  modport master (
    input  req_valid, req_data, tx_done,
    output req_ready, tx_byte, tx_start, busy, grant_idx, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_done,
    input  req_ready, tx_byte, tx_start, busy, grant_idx, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so ptr sits at bit 0, pick the
// lowest set bit, rotate the winner index back.
//   req     request vector
//   ptr     highest-priority index (must be < n)
//   gnt     one-hot grant, zero when nothing requests
//   gnt_idx index of the granted request
//   any     at least one request present
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned n      = 3,
  localparam int unsigned idx_w = idx_width(n)
) (
  input  logic [n-1:0]     req,
  input  logic [idx_w-1:0] ptr,
  output logic [n-1:0]     gnt,
  output logic [idx_w-1:0] gnt_idx,
  output logic             any
);

  localparam int unsigned sum_w = idx_w + 1;
  localparam logic [sum_w-1:0] n_val = sum_w'(n);

  // (a + b) mod n for a, b < n.
  function automatic logic [idx_w-1:0] wrap_add(input logic [idx_w-1:0] a,
                                                input logic [idx_w-1:0] b);
    logic [sum_w-1:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= n_val) sum = sum - n_val;
    return sum[idx_w-1:0];
  endfunction

  logic [n-1:0]     req_rot;
  logic [idx_w-1:0] rot_idx;

  always_comb begin
    req_rot = '0;
    for (int i = 0; i < n; i++) begin
      req_rot[i] = req[wrap_add(ptr, idx_w'(i))];
    end
  end

  always_comb begin
    rot_idx = '0;
    for (int i = n - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_idx = idx_w'(i);
    end
  end

  assign any     = |req;
  assign gnt_idx = wrap_add(rot_idx, ptr);

  always_comb begin
    gnt = '0;
    for (int i = 0; i < n; i++) begin
      gnt[i] = any && (gnt_idx == idx_w'(i));
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between num_req byte producers. A byte is taken from the
// round-robin winner, loaded into the transmitter with tx_start, and the next grant waits
// for tx_done. A watchdog returns to idle if tx_done never arrives.
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  arbiter side of uart_tx_arbiter_if (requester handshake + transmitter load)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned num_req        = 3,
  parameter int unsigned word_width     = word_width_default,
  parameter int unsigned timeout_cycles = 200_000
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned idx_w = idx_width(num_req);
  localparam int unsigned cnt_w = idx_width(timeout_cycles);
  localparam logic [idx_w-1:0] last_idx  = idx_w'(num_req - 1);
  localparam logic [cnt_w-1:0] wdog_last =
      cnt_w'((timeout_cycles == 0) ? 0 : timeout_cycles - 1);
  localparam bit wdog_en = (timeout_cycles != 0);

  state_e                state_q, state_d;
  logic [idx_w-1:0]      ptr_q;
  logic [idx_w-1:0]      grant_idx_q;
  logic [word_width-1:0] tx_byte_q;
  logic [cnt_w-1:0]      wdog_q;
  logic                  timeout_err_q;

  logic [num_req-1:0]    gnt;
  logic [idx_w-1:0]      gnt_idx;
  logic                  any;
  logic [word_width-1:0] win_byte;
  logic                  expire;

  rr_arbiter #(
    .n(num_req)
  ) u_rr (
    .req    (bus.req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < num_req; i++) begin
      if (gnt[i]) win_byte = bus.req_data[i*word_width +: word_width];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; tx_done only matters while waiting
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (any) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: if (bus.tx_done || expire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    bus.tx_start  = 1'b0;
    bus.req_ready = '0;
    expire        = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        bus.tx_start = 1'b1;
        for (int i = 0; i < num_req; i++) begin
          bus.req_ready[i] = (grant_idx_q == idx_w'(i));
        end
      end
      ST_WAIT: expire = wdog_en && !bus.tx_done && (wdog_q == wdog_last);
      default: ;
    endcase
  end

  assign bus.busy = (state_q != ST_IDLE);

  // Datapath: capture on the grant edge, watchdog counts WAIT cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q         <= '0;
      grant_idx_q   <= '0;
      tx_byte_q     <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timeout_err_q <= expire;
      if (state_q == ST_IDLE && any) begin
        tx_byte_q   <= win_byte;
        grant_idx_q <= gnt_idx;
        ptr_q       <= (gnt_idx == last_idx) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == ST_LOAD)      wdog_q <= '0;
      else if (state_q == ST_WAIT) wdog_q <= wdog_q + 1'b1;
    end
  end

  assign bus.tx_byte     = tx_byte_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (3 requesters, 8-bit words, 50-cycle watchdog).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.num_req(3), .word_width(8)) bus ();

  uart_tx_arbiter #(
    .num_req       (3),
    .word_width    (8),
    .timeout_cycles(50)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int max_cycles, input string name);
    bit found;
    found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      @(negedge clk);
      if (bus.tx_start) found = 1'b1;
    end
    check({name, " tx_start seen"}, 32'(found), 32'd1);
  endtask

  // Per-requester ready pulse counter for the fairness run
  bit cnt_en = 1'b0;
  int ready_cnt [3] = '{0, 0, 0};
  always @(negedge clk) begin
    if (cnt_en) begin
      for (int i = 0; i < 3; i++) if (bus.req_ready[i]) ready_cnt[i]++;
    end
  end

  // Row k: inputs held during cycle k, expected outputs during cycle k
  // (outputs reflect inputs of row k-1).
  typedef struct {
    logic [2:0]  vld;
    logic [23:0] data;
    logic        done;
    logic        start;
    logic [2:0]  ready;
    logic [7:0]  tx_b;
    logic        busy;
    logic [1:0]  gidx;
    logic        terr;
  } vec_t;

  localparam int NumVec = 15;
  vec_t vecs [NumVec];

  int       terr_cnt, terr_first;
  logic     busy51, start52;
  logic [7:0] byte52;
  logic [7:0] fair_exp [6];

  initial begin
    // single request to 1, data change after capture, stray tx_done in LOAD and IDLE
    vecs[0]  = '{3'b000, 24'h000000, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{3'b010, 24'h00A500, 1'b0, 1'b0, 3'b000, 8'h00, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{3'b010, 24'h00FF00, 1'b1, 1'b1, 3'b010, 8'hA5, 1'b1, 2'd1, 1'b0};
    vecs[3]  = '{3'b000, 24'h000000, 1'b0, 1'b0, 3'b000, 8'hA5, 1'b1, 2'd1, 1'b0};
    vecs[4]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 8'hA5, 1'b1, 2'd1, 1'b0};
    vecs[5]  = '{3'b000, 24'h000000, 1'b0, 1'b0, 3'b000, 8'hA5, 1'b0, 2'd1, 1'b0};
    vecs[6]  = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 8'hA5, 1'b0, 2'd1, 1'b0};
    vecs[7]  = '{3'b000, 24'h000000, 1'b0, 1'b0, 3'b000, 8'hA5, 1'b0, 2'd1, 1'b0};
    // pointer at 2: grant 2, then with 0 and 2 valid the next grant is 0
    vecs[8]  = '{3'b101, 24'h330011, 1'b0, 1'b0, 3'b000, 8'hA5, 1'b0, 2'd1, 1'b0};
    vecs[9]  = '{3'b101, 24'h330011, 1'b0, 1'b1, 3'b100, 8'h33, 1'b1, 2'd2, 1'b0};
    vecs[10] = '{3'b101, 24'h330011, 1'b1, 1'b0, 3'b000, 8'h33, 1'b1, 2'd2, 1'b0};
    vecs[11] = '{3'b101, 24'h330011, 1'b0, 1'b0, 3'b000, 8'h33, 1'b0, 2'd2, 1'b0};
    vecs[12] = '{3'b101, 24'h330011, 1'b0, 1'b1, 3'b001, 8'h11, 1'b1, 2'd0, 1'b0};
    vecs[13] = '{3'b000, 24'h000000, 1'b1, 1'b0, 3'b000, 8'h11, 1'b1, 2'd0, 1'b0};
    vecs[14] = '{3'b000, 24'h000000, 1'b0, 1'b0, 3'b000, 8'h11, 1'b0, 2'd0, 1'b0};
    fair_exp = '{8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33};

    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_done   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset tx_start",    32'(bus.tx_start),    32'd0);
    check("reset req_ready",   32'(bus.req_ready),   32'd0);
    check("reset tx_byte",     32'(bus.tx_byte),     32'd0);
    check("reset busy",        32'(bus.busy),        32'd0);
    check("reset grant_idx",   32'(bus.grant_idx),   32'd0);
    check("reset timeout_err", 32'(bus.timeout_err), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < NumVec; k++) begin
      @(posedge clk);
      #1;
      bus.req_valid = vecs[k].vld;
      bus.req_data  = vecs[k].data;
      bus.tx_done   = vecs[k].done;
      @(negedge clk);
      check($sformatf("vec%0d tx_start", k),    32'(bus.tx_start),    32'(vecs[k].start));
      check($sformatf("vec%0d req_ready", k),   32'(bus.req_ready),   32'(vecs[k].ready));
      check($sformatf("vec%0d tx_byte", k),     32'(bus.tx_byte),     32'(vecs[k].tx_b));
      check($sformatf("vec%0d busy", k),        32'(bus.busy),        32'(vecs[k].busy));
      check($sformatf("vec%0d grant_idx", k),   32'(bus.grant_idx),   32'(vecs[k].gidx));
      check($sformatf("vec%0d timeout_err", k), 32'(bus.timeout_err), 32'(vecs[k].terr));
    end

    // Fairness: all three hold valid, tx_done 20 cycles after each tx_start
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cnt_en = 1'b1;
    bus.req_data  = 24'h332211;
    bus.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      wait_start(10, $sformatf("fair%0d", k));
      check($sformatf("fair%0d tx_byte", k),   32'(bus.tx_byte),   32'(fair_exp[k]));
      check($sformatf("fair%0d grant_idx", k), 32'(bus.grant_idx), 32'(k % 3));
      check($sformatf("fair%0d req_ready", k), 32'(bus.req_ready), 32'(3'b001) << (k % 3));
      if (k == 5) bus.req_valid = 3'b000;
      repeat (20) @(posedge clk);
      #1;
      bus.tx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    cnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fair ready count %0d", i), 32'(ready_cnt[i]), 32'd2);
    end
    check("fair idle after drain", 32'(bus.busy), 32'd0);

    // Watchdog: no tx_done for requester 0, requester 1 waiting behind it
    bus.req_data  = 24'h005544;
    bus.req_valid = 3'b011;
    wait_start(10, "wdog");
    check("wdog tx_byte",   32'(bus.tx_byte),   32'h44);
    check("wdog grant_idx", 32'(bus.grant_idx), 32'd0);
    bus.req_valid = 3'b010;
    terr_cnt   = 0;
    terr_first = 0;
    busy51     = 1'b1;
    start52    = 1'b0;
    byte52     = 8'h00;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (bus.timeout_err) begin
        terr_cnt++;
        if (terr_first == 0) terr_first = k;
      end
      if (k == 51) busy51 = bus.busy;
      if (k == 52) begin
        start52 = bus.tx_start;
        byte52  = bus.tx_byte;
      end
    end
    check("wdog pulse count",       32'(terr_cnt),   32'd1);
    check("wdog cycles after WAIT", 32'(terr_first), 32'd51);
    check("wdog idle on expiry",    32'(busy51),     32'd0);
    check("wdog next tx_start",     32'(start52),    32'd1);
    check("wdog next tx_byte",      32'(byte52),     32'h55);
    bus.req_valid = 3'b000;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;

    // Reset between edges while waiting on requester 2
    bus.req_data  = 24'h660000;
    bus.req_valid = 3'b100;
    wait_start(10, "rstwait");
    check("rstwait tx_byte",   32'(bus.tx_byte),   32'h66);
    check("rstwait grant_idx", 32'(bus.grant_idx), 32'd2);
    bus.req_valid = 3'b000;
    @(posedge clk);
    #3;
    check("rstwait busy before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwait busy",      32'(bus.busy),      32'd0);
    check("rstwait tx_byte 0", 32'(bus.tx_byte),   32'd0);
    check("rstwait grant 0",   32'(bus.grant_idx), 32'd0);
    check("rstwait tx_start",  32'(bus.tx_start),  32'd0);
    check("rstwait req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_data  = 24'h332211;
    bus.req_valid = 3'b111;
    wait_start(10, "postrst");
    check("postrst grant_idx", 32'(bus.grant_idx), 32'd0);
    check("postrst tx_byte",   32'(bus.tx_byte),   32'h11);
    check("postrst req_ready", 32'(bus.req_ready), 32'b001);
    bus.req_valid = 3'b000;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b1;
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
